issue_scoreboard: RTL

Register scoreboard and pipeline-occupancy controller for the in-order issue stage. It tracks which architectural registers have a write in flight and whether a control-transfer instruction is unresolved. It drives the decoder's busy_reg and jmp_op_in_pipeline inputs, and consumes issue and writeback/resolve events from the pipeline. It also bounds in-flight instructions and raises a stall when that bound is reached.

---
 rtl/issue_scoreboard.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : issue_scoreboard
//  Purpose  : Register scoreboard and pipeline-occupancy controller for the
//             in-order issue stage. Tracks registers with a write in flight,
//             unresolved control transfers and the number of issued-but-not-
//             retired instructions. Raises a stall when either bound is hit.
//  Ports    :
//    clk, rst_n            clock (rising edge), asynchronous active-low reset
//    issue_fire/rd/wb/jmp  issue event from the decoder
//    wb0_valid/rd          ALU writeback port
//    wb1_valid/rd          memory writeback port
//    jmp_resolve           one jump/branch resolved this cycle
//    retire                one instruction left the pipeline this cycle
//    flush                 synchronous pipeline flush
//    busy_reg              per-register write-pending bits (bit 0 always 0)
//    jmp_op_in_pipeline    at least one unresolved jump
//    issue_stall           in-flight or jump bound reached
//    inflight              current in-flight instruction count
//    err                   sticky protocol-violation flag
//  Revision : 1.0  initial release
// ============================================================================
module issue_scoreboard #(
    parameter int MAX_INFLIGHT = 4,   // 1..15
    parameter int MAX_JMP      = 1    // 1..3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_fire,
    input  logic [4:0]  issue_rd,
    input  logic        issue_wb,
    input  logic        issue_jmp,
    input  logic        wb0_valid,
    input  logic [4:0]  wb0_rd,
    input  logic        wb1_valid,
    input  logic [4:0]  wb1_rd,
    input  logic        jmp_resolve,
    input  logic        retire,
    input  logic        flush,
    output logic [31:0] busy_reg,
    output logic        jmp_op_in_pipeline,
    output logic        issue_stall,
    output logic [3:0]  inflight,
    output logic        err
);

    localparam logic [3:0] c_MAX_INFLIGHT = 4'(MAX_INFLIGHT);
    localparam logic [1:0] c_MAX_JMP      = 2'(MAX_JMP);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0] r_busy;
    logic [1:0]  r_jcnt;
    logic [3:0]  r_inflight;
    logic        r_err;

    // ------------------------------------------------------------------------
    // Combinational next-state terms
    // ------------------------------------------------------------------------
    logic        w_stall;
    logic        w_accept;
    logic        w_jmp_inc;
    logic [31:0] w_set_mask;
    logic [31:0] w_wb0_mask;
    logic [31:0] w_wb1_mask;
    logic [31:0] w_clr_mask;
    logic [31:0] w_busy_next;
    logic        w_wb0_stray;
    logic        w_wb1_stray;
    logic        w_wb_dup;
    logic        w_jmp_underflow;
    logic        w_ret_underflow;
    logic        w_issue_blocked;
    logic        w_err_evt;
    logic [1:0]  w_jcnt_next;
    logic [3:0]  w_inflight_next;

    assign w_stall   = (r_inflight == c_MAX_INFLIGHT) || (r_jcnt == c_MAX_JMP);
    assign w_accept  = issue_fire && !w_stall;
    assign w_jmp_inc = w_accept && issue_jmp;

    // Register 0 is hard-wired: never set, writebacks to it are dropped.
    always_comb begin
        w_set_mask = '0;
        w_wb0_mask = '0;
        w_wb1_mask = '0;
        if (w_accept && issue_wb && (issue_rd != 5'd0)) begin
            w_set_mask[issue_rd] = 1'b1;
        end
        if (wb0_valid && (wb0_rd != 5'd0)) begin
            w_wb0_mask[wb0_rd] = 1'b1;
        end
        if (wb1_valid && (wb1_rd != 5'd0)) begin
            w_wb1_mask[wb1_rd] = 1'b1;
        end
    end

    assign w_clr_mask = w_wb0_mask | w_wb1_mask;

    // A same-cycle issue to a register being written back is the new
    // producer, so the set is applied after the clear.
    assign w_busy_next = ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'h1;

    // Writeback to a register nobody is (or is about to be) producing.
    assign w_wb0_stray = |(w_wb0_mask & ~(r_busy | w_set_mask));
    assign w_wb1_stray = |(w_wb1_mask & ~(r_busy | w_set_mask));

    // Both ports naming the same live register: one clear, but a violation.
    assign w_wb_dup = wb0_valid && wb1_valid && (wb0_rd == wb1_rd) && (wb0_rd != 5'd0);

    assign w_jmp_underflow = jmp_resolve && !w_jmp_inc && (r_jcnt == 2'd0);
    assign w_ret_underflow = retire && !w_accept && (r_inflight == 4'd0);
    assign w_issue_blocked = issue_fire && w_stall;

    assign w_err_evt = w_wb0_stray | w_wb1_stray | w_wb_dup |
                       w_jmp_underflow | w_ret_underflow | w_issue_blocked;

    always_comb begin
        w_jcnt_next = r_jcnt;
        if (w_jmp_inc && !jmp_resolve) begin
            if (r_jcnt != c_MAX_JMP) begin
                w_jcnt_next = r_jcnt + 2'd1;
            end
        end else if (!w_jmp_inc && jmp_resolve) begin
            if (r_jcnt != 2'd0) begin
                w_jcnt_next = r_jcnt - 2'd1;
            end
        end
    end

    always_comb begin
        w_inflight_next = r_inflight;
        if (w_accept && !retire) begin
            if (r_inflight != c_MAX_INFLIGHT) begin
                w_inflight_next = r_inflight + 4'd1;
            end
        end else if (!w_accept && retire) begin
            if (r_inflight != 4'd0) begin
                w_inflight_next = r_inflight - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers. Flush discards all other events of its cycle, err included.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_jcnt     <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else if (flush) begin
            r_busy     <= '0;
            r_jcnt     <= '0;
            r_inflight <= '0;
        end else begin
            r_busy     <= w_busy_next;
            r_jcnt     <= w_jcnt_next;
            r_inflight <= w_inflight_next;
            r_err      <= r_err | w_err_evt;
        end
    end

    assign busy_reg           = r_busy;
    assign jmp_op_in_pipeline = (r_jcnt != 2'd0);
    assign issue_stall        = w_stall;
    assign inflight           = r_inflight;
    assign err                = r_err;

endmodule
`default_nettype wire
